// File: rtl/axis_master.sv
`default_nettype none
// ============================================================================
//  Module      : axis_master
//  Description : Backend-to-AXI-Stream transmitter. Backend words are taken
//                over a valid/ready handshake, buffered in a DEPTH-entry
//                circular FIFO and presented as an AXI-Stream master with
//                tstrb/tkeep/tuser/tlast sidebands.
//                Optional store-and-forward mode: define AXIS_MASTER_SF_EN.
//                When undefined the block runs cut-through.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_master #(
    parameter int DEPTH = 4
) (
    input  logic                     axi_aclk,
    input  logic                     axi_aresetn,
    input  logic [31:0]              bk_data,
    input  logic [3:0]               bk_tstrb,
    input  logic [3:0]               bk_tkeep,
    input  logic [1:0]               bk_user,
    input  logic                     bk_tlast,
    input  logic                     bk_valid,
    output logic                     bk_ready,
    output logic [31:0]              axis_tdata,
    output logic [3:0]               axis_tstrb,
    output logic [3:0]               axis_tkeep,
    output logic [1:0]               axis_tuser,
    output logic                     axis_tlast,
    output logic                     axis_tvalid,
    input  logic                     axis_tready,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int c_AW = $clog2(DEPTH);   // address bits
    localparam int c_PW = c_AW + 1;        // pointer bits (extra wrap bit)
    localparam int c_EW = 43;              // {data, strb, keep, user, last}

    logic [c_PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PW-1:0] rd_ptr_q, rd_ptr_d;
    logic            bk_ready_q, bk_ready_d;
    logic [c_EW-1:0] mem_q [DEPTH];

    logic            w_empty;
    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_tvalid;
    logic            w_head_last;
    logic [c_EW-1:0] w_head;
    logic [c_EW-1:0] w_wr_entry;
    logic [c_PW-1:0] w_count_next;

    assign w_empty     = (wr_ptr_q == rd_ptr_q);
    assign w_full      = (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]) &&
                         (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]);
    assign w_push      = bk_valid && bk_ready_q;
    assign w_pop       = w_tvalid && axis_tready;
    assign w_wr_entry  = {bk_data, bk_tstrb, bk_tkeep, bk_user, bk_tlast};
    assign w_head_last = mem_q[rd_ptr_q[c_AW-1:0]][0];

    // Head entry is forced to zero while the FIFO is empty
    assign w_head      = w_empty ? '0 : mem_q[rd_ptr_q[c_AW-1:0]];

    assign axis_tdata  = w_head[42:11];
    assign axis_tstrb  = w_head[10:7];
    assign axis_tkeep  = w_head[6:3];
    assign axis_tuser  = w_head[2:1];
    assign axis_tlast  = w_head[0];
    assign axis_tvalid = w_tvalid;
    assign bk_ready    = bk_ready_q;
    assign fifo_count  = wr_ptr_q - rd_ptr_q;

`ifdef AXIS_MASTER_SF_EN
    logic [c_PW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic            in_pkt_q, in_pkt_d;

    // Store-and-forward: hold the head until a whole packet is buffered,
    // the FIFO fills (long packets), or a packet is already in flight
    assign w_tvalid = !w_empty && ((pkt_cnt_q != '0) || w_full || in_pkt_q);

    // Track buffered packet ends and whether a packet has started streaming
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        in_pkt_d  = in_pkt_q;
        case ({w_push && bk_tlast, w_pop && w_head_last})
            2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
            2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
        if (w_pop) begin
            in_pkt_d = !w_head_last;
        end
    end

    // Packet-tracking registers
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            pkt_cnt_q <= '0;
            in_pkt_q  <= 1'b0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
            in_pkt_q  <= in_pkt_d;
        end
    end
`else
    // Cut-through: any buffered word is offered immediately
    assign w_tvalid = !w_empty;
`endif

    // Pointer advance and registered backend ready (no write-through on full)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        w_count_next = wr_ptr_d - rd_ptr_d;
        bk_ready_d   = (w_count_next != c_PW'(DEPTH));
    end

    // Pointer and ready registers
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            bk_ready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            bk_ready_q <= bk_ready_d;
        end
    end

    // Storage array; contents need no reset since pointers gate visibility
    always_ff @(posedge axi_aclk) begin
        if (w_push) begin
            mem_q[wr_ptr_q[c_AW-1:0]] <= w_wr_entry;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_master
//  Description : Self-checking bench for axis_master (DEPTH=4). A queue-based
//                reference model is compared against the DUT every cycle;
//                directed scenarios add literal expectations.
//                Store-and-forward scenarios run when AXIS_MASTER_SF_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_master;

    localparam int DEPTH = 4;

    logic        axi_aclk = 1'b0;
    logic        axi_aresetn = 1'b0;
    logic [31:0] bk_data = '0;
    logic [3:0]  bk_tstrb = '0;
    logic [3:0]  bk_tkeep = '0;
    logic [1:0]  bk_user = '0;
    logic        bk_tlast = 1'b0;
    logic        bk_valid = 1'b0;
    logic        bk_ready;
    logic [31:0] axis_tdata;
    logic [3:0]  axis_tstrb;
    logic [3:0]  axis_tkeep;
    logic [1:0]  axis_tuser;
    logic        axis_tlast;
    logic        axis_tvalid;
    logic        axis_tready = 1'b0;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    axis_master #(.DEPTH(DEPTH)) dut (
        .axi_aclk    (axi_aclk),
        .axi_aresetn (axi_aresetn),
        .bk_data     (bk_data),
        .bk_tstrb    (bk_tstrb),
        .bk_tkeep    (bk_tkeep),
        .bk_user     (bk_user),
        .bk_tlast    (bk_tlast),
        .bk_valid    (bk_valid),
        .bk_ready    (bk_ready),
        .axis_tdata  (axis_tdata),
        .axis_tstrb  (axis_tstrb),
        .axis_tkeep  (axis_tkeep),
        .axis_tuser  (axis_tuser),
        .axis_tlast  (axis_tlast),
        .axis_tvalid (axis_tvalid),
        .axis_tready (axis_tready),
        .fifo_count  (fifo_count)
    );

    always #5 axi_aclk = ~axi_aclk;
    always @(posedge axi_aclk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model: a plain queue of entries -------------
    logic [42:0] mq[$];
    bit          m_ready = 1'b0;
    bit          m_inpkt = 1'b0;

    function automatic bit m_tvalid();
        bit anylast;
        if (mq.size() == 0) return 1'b0;
`ifdef AXIS_MASTER_SF_EN
        anylast = 1'b0;
        foreach (mq[i]) if (mq[i][0]) anylast = 1'b1;
        return anylast || (mq.size() == DEPTH) || m_inpkt;
`else
        anylast = 1'b1;
        return anylast;
`endif
    endfunction

    always @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            mq.delete();
            m_ready = 1'b0;
            m_inpkt = 1'b0;
        end else begin
            bit pu, po;
            pu = bk_valid && m_ready;
            po = m_tvalid() && axis_tready;
            if (po) begin
                m_inpkt = !mq[0][0];
                void'(mq.pop_front());
            end
            if (pu) mq.push_back({bk_data, bk_tstrb, bk_tkeep, bk_user, bk_tlast});
            m_ready = (mq.size() != DEPTH);
        end
    end

    // ---------------- per-cycle compare + beat log + stall stability --------
    logic [42:0] log_q[$];
    int          log_c[$];
    bit          prev_stall = 1'b0;
    logic [42:0] prev_pl = '0;

    always @(negedge axi_aclk) begin
        logic [42:0] exp_pl, act_pl;
        exp_pl = (mq.size() != 0) ? mq[0] : 43'd0;
        act_pl = {axis_tdata, axis_tstrb, axis_tkeep, axis_tuser, axis_tlast};
        chk("tvalid",     axis_tvalid, m_tvalid());
        chk("payload",    act_pl,      exp_pl);
        chk("fifo_count", fifo_count,  mq.size());
        chk("bk_ready",   bk_ready,    m_ready);
        if (prev_stall && axi_aresetn) begin
            chk("stall_tvalid_held",  axis_tvalid, 1'b1);
            chk("stall_payload_held", act_pl,      prev_pl);
        end
        prev_stall = axis_tvalid && !axis_tready && axi_aresetn;
        prev_pl    = act_pl;
        if (axis_tvalid && axis_tready && axi_aresetn) begin
            log_q.push_back(act_pl);
            log_c.push_back(cyc);
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d, input logic [3:0] s, input logic [3:0] k,
                             input logic [1:0] u, input logic l);
        bit acc = 1'b0;
        bk_data = d; bk_tstrb = s; bk_tkeep = k; bk_user = u; bk_tlast = l;
        bk_valid = 1'b1;
        for (int n = 0; n < 60 && !acc; n++) begin
            acc = bk_ready;
            tick();
        end
        chk("push_accepted", acc, 1'b1);
        bk_valid = 1'b0;
    endtask

    task automatic check_log(input string nm, input logic [31:0] base, input int n);
        chk({nm, "_beats"}, log_q.size(), n);
        for (int i = 0; i < n && i < log_q.size(); i++)
            chk({nm, "_data"}, log_q[i][42:11], base + i);
    endtask

    initial begin
        // ---- reset state ----
        repeat (3) tick();
        chk("rst_bk_ready", bk_ready, 1'b0);
        chk("rst_tvalid",   axis_tvalid, 1'b0);
        chk("rst_count",    fifo_count, 3'd0);
        axi_aresetn = 1'b1;
        tick();
        chk("ready_after_release", bk_ready, 1'b1);

        // ---- single word ----
        axis_tready = 1'b1;
        push_word(32'hDEADBEEF, 4'hF, 4'hF, 2'd2, 1'b1);
        chk("single_tvalid", axis_tvalid, 1'b1);
        chk("single_tdata",  axis_tdata, 32'hDEADBEEF);
        chk("single_tstrb",  axis_tstrb, 4'hF);
        chk("single_tkeep",  axis_tkeep, 4'hF);
        chk("single_tuser",  axis_tuser, 2'd2);
        chk("single_tlast",  axis_tlast, 1'b1);
        tick();
        chk("single_count_back0", fifo_count, 3'd0);
        chk("single_tvalid_off",  axis_tvalid, 1'b0);

        // ---- fill to full with sink stalled, then drain ----
        repeat (2) tick();
        log_q.delete(); log_c.delete();
        axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(32'h100 + i, 4'h3, 4'h7, 2'd1, 1'b0);
        chk("full_count",    fifo_count, 3'd4);
        chk("full_bk_ready", bk_ready, 1'b0);
        fork
            begin
                push_word(32'h104, 4'h3, 4'h7, 2'd1, 1'b0);
                push_word(32'h105, 4'h3, 4'h7, 2'd1, 1'b1);
            end
            begin
                repeat (3) tick();
                chk("held_count", fifo_count, 3'd4);
                axis_tready = 1'b1;
            end
        join
        repeat (8) tick();
        check_log("drain", 32'h100, 6);

        // ---- continuous 16 words, no bubbles ----
        log_q.delete(); log_c.delete();
        axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) push_word(i, 4'hF, 4'hF, 2'd0, 1'b1);
        repeat (4) tick();
        check_log("stream16", 32'h0, 16);
        for (int i = 1; i < 16 && i < log_c.size(); i++)
            chk("stream16_no_bubble", log_c[i] - log_c[i-1], 1);

        // ---- sink toggling every cycle ----
        log_q.delete(); log_c.delete();
        fork
            for (int i = 0; i < 8; i++) push_word(32'h200 + i, 4'hA, 4'h5, 2'd3, 1'b1);
            for (int t = 0; t < 30; t++) begin
                axis_tready = ~axis_tready;
                tick();
            end
        join
        axis_tready = 1'b1;
        repeat (8) tick();
        check_log("toggle", 32'h200, 8);

`ifdef AXIS_MASTER_SF_EN
        // ---- store-and-forward: hold until tlast ----
        log_q.delete(); log_c.delete();
        push_word(32'h300, 4'hF, 4'hF, 2'd0, 1'b0);
        chk("sf_hold1", axis_tvalid, 1'b0);
        push_word(32'h301, 4'hF, 4'hF, 2'd0, 1'b0);
        chk("sf_hold2", axis_tvalid, 1'b0);
        push_word(32'h302, 4'hF, 4'hF, 2'd0, 1'b1);
        chk("sf_release", axis_tvalid, 1'b1);
        repeat (5) tick();
        check_log("sf3", 32'h300, 3);
        for (int i = 1; i < 3 && i < log_c.size(); i++)
            chk("sf3_back_to_back", log_c[i] - log_c[i-1], 1);

        // ---- store-and-forward: packet longer than DEPTH ----
        log_q.delete(); log_c.delete();
        for (int i = 0; i < 6; i++) push_word(32'h400 + i, 4'hF, 4'hF, 2'd0, i == 5);
        repeat (8) tick();
        check_log("sf6", 32'h400, 6);
        for (int i = 0; i < 6 && i < log_q.size(); i++)
            chk("sf6_tlast", log_q[i][0], i == 5);
`endif

        // ---- reset with words buffered ----
        axis_tready = 1'b0;
        push_word(32'h500, 4'hF, 4'hF, 2'd1, 1'b1);
        push_word(32'h501, 4'hF, 4'hF, 2'd1, 1'b1);
        chk("pre_reset_count", fifo_count, 3'd2);
        #2;
        axi_aresetn = 1'b0;
        #1;
        chk("rst_mid_tvalid", axis_tvalid, 1'b0);
        chk("rst_mid_tdata",  axis_tdata, 32'h0);
        chk("rst_mid_count",  fifo_count, 3'd0);
        chk("rst_mid_ready",  bk_ready, 1'b0);
        tick();
        axi_aresetn = 1'b1;
        log_q.delete(); log_c.delete();
        axis_tready = 1'b1;
        repeat (5) tick();
        chk("no_stale_beats", log_q.size(), 0);
        chk("post_rst_tvalid", axis_tvalid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
